// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared op encodings, FSM states and helpers for mux_gate_sequencer
package mux_seq_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT_A   = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_NAND    = 3'd4;
  localparam logic [2:0] OP_NOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Ops that need a temp pass before the result bit can be formed
  function automatic logic is_two_pass(input logic [2:0] op);
    return (op == OP_XOR) || (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/mux2x1_cell.sv
// rtl/mux2x1_cell.sv - single combinational 2:1 mux cell used as a universal gate
// Ports:
//   sel - select; i1 chosen when high, i0 when low
//   i1  - data input for sel=1
//   i0  - data input for sel=0
//   y   - mux output
module mux2x1_cell (
  input  logic sel,
  input  logic i1,
  input  logic i0,
  output logic y
);

  assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// rtl/mux_gate_sequencer.sv - bit-serial logic unit sequencing one shared 2:1 mux cell
// Evaluates a bitwise op on two WIDTH-bit operands, LSB first, one or two mux
// passes per bit, with a start/busy/done handshake.
// Optional build macro: MUX_SEQ_PASS_CNT_EN adds the pass_cnt output.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - request, sampled only in IDLE
//   op       - 0 AND, 1 OR, 2 NOT_A, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 invalid
//   a, b     - operands, captured on accepted start
//   busy     - high while evaluating
//   done     - one-cycle pulse, y/err valid
//   err      - invalid-op flag, held until next accepted start
//   y        - result, held until next accepted start
//   pass_cnt - (MUX_SEQ_PASS_CNT_EN only) mux passes of current/last op
module mux_gate_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] y
`ifdef MUX_SEQ_PASS_CNT_EN
  ,
  output logic [$clog2(2*WIDTH+1)-1:0] pass_cnt
`endif
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             t_q, t_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;

  logic mux_sel, mux_i1, mux_i0, mux_y;

  mux2x1_cell u_cell (
    .sel (mux_sel),
    .i1  (mux_i1),
    .i0  (mux_i0),
    .y   (mux_y)
  );

`ifdef MUX_SEQ_PASS_CNT_EN
  localparam int CW = $clog2(2*WIDTH+1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign pass_cnt = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      t_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
`ifdef MUX_SEQ_PASS_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      err_q   <= err_d;
`ifdef MUX_SEQ_PASS_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    err_d   = err_q;
    mux_sel = 1'b0;
    mux_i1  = 1'b0;
    mux_i0  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef MUX_SEQ_PASS_CNT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MUX_SEQ_PASS_CNT_EN
          cnt_d = '0;
`endif
          if (op == OP_INVALID) begin
            // y deliberately untouched so the previous result survives
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            y_d     = '0;
            err_d   = 1'b0;
            k_d     = '0;
            t_d     = 1'b0;
            state_d = ST_PASS1;
          end
        end
      end

      ST_PASS1: begin
        busy = 1'b1;
`ifdef MUX_SEQ_PASS_CNT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        case (op_q)
          OP_AND, OP_NAND: begin
            mux_sel = a_q[k_q];
            mux_i1  = b_q[k_q];
            mux_i0  = 1'b0;
          end
          OP_OR, OP_NOR: begin
            mux_sel = a_q[k_q];
            mux_i1  = 1'b1;
            mux_i0  = b_q[k_q];
          end
          OP_NOT_A: begin
            mux_sel = a_q[k_q];
            mux_i1  = 1'b0;
            mux_i0  = 1'b1;
          end
          default: begin
            // XOR/XNOR first form t = ~b[k]
            mux_sel = b_q[k_q];
            mux_i1  = 1'b0;
            mux_i0  = 1'b1;
          end
        endcase

        if (is_two_pass(op_q)) begin
          t_d     = mux_y;
          state_d = ST_PASS2;
        end else begin
          y_d[k_q] = mux_y;
          if (k_q == K_LAST) begin
            state_d = ST_FIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_PASS1;
          end
        end
      end

      ST_PASS2: begin
        busy = 1'b1;
`ifdef MUX_SEQ_PASS_CNT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        case (op_q)
          OP_NAND, OP_NOR: begin
            mux_sel = t_q;
            mux_i1  = 1'b0;
            mux_i0  = 1'b1;
          end
          OP_XOR: begin
            mux_sel = a_q[k_q];
            mux_i1  = t_q;
            mux_i0  = b_q[k_q];
          end
          default: begin
            mux_sel = a_q[k_q];
            mux_i1  = b_q[k_q];
            mux_i0  = t_q;
          end
        endcase

        y_d[k_q] = mux_y;
        if (k_q == K_LAST) begin
          state_d = ST_FIN;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_PASS1;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign y   = y_q;
  assign err = err_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// tb/tb_mux_gate_sequencer.sv - scoreboard bench for mux_gate_sequencer
module tb_mux_gate_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, err;
  logic [W-1:0] y;
`ifdef MUX_SEQ_PASS_CNT_EN
  logic [$clog2(2*W+1)-1:0] pass_cnt;
`endif

  mux_gate_sequencer #(.WIDTH(W)) dut (
`ifdef MUX_SEQ_PASS_CNT_EN
    .pass_cnt (pass_cnt),
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .y     (y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           cyc;
    int           pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_y = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return ~x;
      3'd3:    return x ^ z;
      3'd4:    return ~(x & z);
      3'd5:    return ~(x | z);
      3'd6:    return ~(x ^ z);
      default: return last_y;
    endcase
  endfunction

  function automatic int passes_per_bit(input logic [2:0] o);
    if (o == 3'd7) return 0;
    if (o >= 3'd3) return 2;
    return 1;
  endfunction

  // Monitor: whenever the DUT signals done, pop and compare
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("err", 32'(err), 32'(e.err));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
`ifdef MUX_SEQ_PASS_CNT_EN
        chk("pass_cnt", 32'(pass_cnt), 32'(e.pc));
`endif
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge that starts the
  // cycle following done, the earliest legal restart point.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                        input bit junk_starts);
    exp_t e;
    int   ppb;
    int   lat;
    ppb   = passes_per_bit(o);
    lat   = (ppb == 0) ? 1 : ppb * W + 1;
    e.y   = ref_y(o, x, z);
    e.err = (o == 3'd7);
    e.cyc = cyc + lat;
    e.pc  = ppb * W;
    q.push_back(e);
    last_y = e.y;
    start = 1'b1; op = o; a = x; b = z;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      // inputs may wander after acceptance; extra starts must be ignored
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 3'($urandom);
      start = junk_starts && (i == 3 || i == lat);
      if (i == 1 && ppb != 0) chk("busy_after_start", 32'(busy), 32'd1);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 8'hF0, 8'h3C, 1'b1);   // AND 30, with ignored starts
    run_op(3'd7, 8'h11, 8'h22, 1'b0);   // invalid: y stays 30
    run_op(3'd1, 8'hF0, 8'h3C, 1'b0);   // OR FC
    run_op(3'd3, 8'hA5, 8'h0F, 1'b0);   // XOR AA
    run_op(3'd6, 8'hA5, 8'h0F, 1'b0);   // XNOR 55
    run_op(3'd4, 8'hFF, 8'hFF, 1'b0);   // NAND 00
    run_op(3'd2, 8'h5A, 8'h00, 1'b0);   // NOT_A A5
    run_op(3'd5, 8'h0C, 8'h30, 1'b0);   // NOR C3

    // Reset held mid-XOR: aborts without a done pulse
    start = 1'b1; op = 3'd3; a = 8'hA5; b = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
`ifdef MUX_SEQ_PASS_CNT_EN
    chk("abort_pass_cnt", 32'(pass_cnt), 32'd0);
`endif
    rst_n  = 1'b1;
    last_y = '0;
    repeat (25) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
